// File: rtl/mem_fill_arbiter_if.sv
// Cache-side and memory-side signals of the fill arbiter.
// slave is the arbiter view, master is the cache/memory view.
interface mem_fill_arbiter_if #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8
);
  localparam int WB = $clog2(WORDS_PER_BLOCK);

  logic              icache_req;
  logic [ADDR_W-1:0] icache_addr;
  logic              dcache_req;
  logic [ADDR_W-1:0] dcache_addr;
  logic              dcache_wr_req;
  logic [ADDR_W-1:0] dcache_wr_addr;
  logic [DATA_W-1:0] dcache_wr_data;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_data_valid;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] fill_data;
  logic [WB-1:0]     fill_word;
  logic              icache_fill_we;
  logic              dcache_fill_we;
  logic              icache_fill_done;
  logic              dcache_fill_done;
  logic              dcache_wr_ack;
  logic              icache_fill_busy;
  logic              dcache_fill_busy;

  modport slave (
    input  icache_req, icache_addr,
    input  dcache_req, dcache_addr,
    input  dcache_wr_req, dcache_wr_addr,
    input  dcache_wr_data,
    input  mem_data_valid, mem_data_out,
    output mem_en, mem_wr, mem_addr,
    output mem_data_in,
    output fill_data, fill_word,
    output icache_fill_we, dcache_fill_we,
    output icache_fill_done,
    output dcache_fill_done,
    output dcache_wr_ack,
    output icache_fill_busy,
    output dcache_fill_busy
  );

  modport master (
    output icache_req, icache_addr,
    output dcache_req, dcache_addr,
    output dcache_wr_req, dcache_wr_addr,
    output dcache_wr_data,
    output mem_data_valid, mem_data_out,
    input  mem_en, mem_wr, mem_addr,
    input  mem_data_in,
    input  fill_data, fill_word,
    input  icache_fill_we, dcache_fill_we,
    input  icache_fill_done,
    input  dcache_fill_done,
    input  dcache_wr_ack,
    input  icache_fill_busy,
    input  dcache_fill_busy
  );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Shares the main-memory port between I-cache fills,
// D-cache fills and D-cache write-through stores.
module mem_fill_arbiter #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_fill_arbiter_if.slave bus
);
  localparam int WB = $clog2(WORDS_PER_BLOCK);
  localparam logic [WB-1:0] LAST =
    WB'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_W-1:0] OFF =
    ADDR_W'(2 * WORDS_PER_BLOCK - 1);

  if (WORDS_PER_BLOCK < 2 ||
      (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0 ||
      MEM_LATENCY < 1 || DATA_W < 1) begin : g_bad_param
    $error("mem_fill_arbiter: bad parameters");
  end

  typedef enum logic [1:0] {
    IDLE, ISSUE, DRAIN, DONE
  } state_t;

  state_t            state, state_n;
  logic              gnt_d, gnt_d_n;
  logic [ADDR_W-1:0] base, base_n;
  logic [WB-1:0]     issue_cnt, issue_n;
  logic [WB-1:0]     rx_cnt, rx_n;
  logic              prefer_i, prefer_n;
  logic              take_wr, take_d, take_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt_d     <= 1'b0;
      base      <= '0;
      issue_cnt <= '0;
      rx_cnt    <= '0;
      prefer_i  <= 1'b0;
    end else begin
      state     <= state_n;
      gnt_d     <= gnt_d_n;
      base      <= base_n;
      issue_cnt <= issue_n;
      rx_cnt    <= rx_n;
      prefer_i  <= prefer_n;
    end
  end

  // one-hot IDLE grant: store first, then miss with fairness
  assign take_wr = bus.dcache_wr_req;
  assign take_d  = ~take_wr & bus.dcache_req &
                   ~(bus.icache_req & prefer_i);
  assign take_i  = ~take_wr & bus.icache_req &
                   ~(bus.dcache_req & ~prefer_i);

  always_comb begin
    state_n              = state;
    gnt_d_n              = gnt_d;
    base_n               = base;
    issue_n              = issue_cnt;
    rx_n                 = rx_cnt;
    prefer_n             = prefer_i;
    bus.mem_en           = 1'b0;
    bus.mem_wr           = 1'b0;
    bus.mem_addr         = '0;
    bus.mem_data_in      = '0;
    bus.icache_fill_we   = 1'b0;
    bus.dcache_fill_we   = 1'b0;
    bus.icache_fill_done = 1'b0;
    bus.dcache_fill_done = 1'b0;
    bus.dcache_wr_ack    = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          take_wr: begin
            bus.mem_en        = 1'b1;
            bus.mem_wr        = 1'b1;
            bus.mem_addr      = bus.dcache_wr_addr;
            bus.mem_data_in   = bus.dcache_wr_data;
            bus.dcache_wr_ack = 1'b1;
            prefer_n          = bus.icache_req;
            state_n           = DONE;
          end
          take_d: begin
            gnt_d_n = 1'b1;
            base_n  = bus.dcache_addr & ~OFF;
            issue_n = '0;
            rx_n    = '0;
            state_n = ISSUE;
          end
          take_i: begin
            gnt_d_n = 1'b0;
            base_n  = bus.icache_addr & ~OFF;
            issue_n = '0;
            rx_n    = '0;
            state_n = ISSUE;
          end
          default: ;
        endcase
      end
      ISSUE: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = base + (ADDR_W'(issue_cnt) << 1);
        issue_n      = issue_cnt + WB'(1);
        if (issue_cnt == LAST) state_n = DRAIN;
      end
      DRAIN: ;
      DONE:  state_n = IDLE;
    endcase
    // returns may overlap issue; the last one ends the fill
    if ((state == ISSUE || state == DRAIN) &&
        bus.mem_data_valid) begin
      bus.icache_fill_we = ~gnt_d;
      bus.dcache_fill_we = gnt_d;
      rx_n               = rx_cnt + WB'(1);
      if (rx_cnt == LAST) begin
        bus.icache_fill_done = ~gnt_d;
        bus.dcache_fill_done = gnt_d;
        prefer_n = gnt_d & bus.icache_req;
        state_n  = DONE;
      end
    end
  end

  assign bus.fill_data = bus.mem_data_out;
  assign bus.fill_word = rx_cnt;
  assign bus.icache_fill_busy =
    bus.icache_req & ~bus.icache_fill_done;
  assign bus.dcache_fill_busy =
    bus.dcache_req & ~bus.dcache_fill_done;
endmodule
